alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational ALU (alu modport: aluop, port_a, port_b in; port_o, n, z, v out) between NREQ requesters, e.g. the execute stage and a branch/address unit.
- Each requester presents an op plus two operands and holds a request line.
- The arbiter grants one requester, drives the ALU from registered operands, and captures the result and flags.
- It then returns them to the winner with a one-cycle done pulse.

---
 rtl/alu_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Round-robin arbiter and sequencer that shares one external combinational
// ALU between NREQ requesters. A grant latches the winner's opcode and
// operands into registers that drive the ALU. One cycle later the ALU result
// and flags are captured. The winner then gets a one-cycle done pulse while
// the captured result is presented on res_*.
//
// Sequence: IDLE (arbitrate/latch) -> ISSUE (capture) -> RESP (done) -> IDLE
//
// Ports
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   req             per-requester request, held until that requester's done
//   req_aluop       per-requester opcode, slice i belongs to requester i
//   req_a, req_b    per-requester operands, slice i belongs to requester i
//   done            one-hot, one-cycle completion pulse to the owner
//   res_o/n/z/v     captured result and flags, valid while done is high
//   busy            high whenever the sequencer is not in IDLE
//   alu_aluop/port_a/port_b   registered drive to the shared ALU
//   alu_port_o, alu_n/z/v     combinational result and flags from the ALU
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NREQ   = 2,
  parameter int WORD_W = 32,
  parameter int OP_W   = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*OP_W-1:0]   req_aluop,
  input  logic [NREQ*WORD_W-1:0] req_a,
  input  logic [NREQ*WORD_W-1:0] req_b,
  output logic [NREQ-1:0]        done,
  output logic [WORD_W-1:0]      res_o,
  output logic                   res_n,
  output logic                   res_z,
  output logic                   res_v,
  output logic                   busy,
  output logic [OP_W-1:0]        alu_aluop,
  output logic [WORD_W-1:0]      alu_port_a,
  output logic [WORD_W-1:0]      alu_port_b,
  input  logic [WORD_W-1:0]      alu_port_o,
  input  logic                   alu_n,
  input  logic                   alu_z,
  input  logic                   alu_v
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] owner;

  logic             found;
  logic [IDX_W-1:0] winner;
  int               idx;

  // Round-robin pick: first set request scanning upward from last_grant+1,
  // wrapping modulo NREQ (works for non-power-of-two NREQ as well).
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip the assignment infer a latch.
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(last_grant) + 1 + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NREQ - 1);
      owner      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      res_o      <= '0;
      res_n      <= 1'b0;
      res_z      <= 1'b0;
      res_v      <= 1'b0;
      alu_aluop  <= '0;
      alu_port_a <= '0;
      alu_port_b <= '0;
    end else begin
      // done is a pulse: cleared every cycle unless set below
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            alu_aluop  <= req_aluop[winner*OP_W +: OP_W];
            alu_port_a <= req_a[winner*WORD_W +: WORD_W];
            alu_port_b <= req_b[winner*WORD_W +: WORD_W];
            owner      <= winner;
            state      <= ISSUE;
            busy       <= 1'b1;
          end
        end
        ISSUE: begin
          // ALU inputs have been stable from registers for this whole cycle
          res_o       <= alu_port_o;
          res_n       <= alu_n;
          res_z       <= alu_z;
          res_v       <= alu_v;
          done[owner] <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          // requests seen here wait for the next IDLE decision
          last_grant <= owner;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter with NREQ=2. A small combinational ALU stands
// in for the shared ALU (ADD/SUB with n/z/v flags). Each scenario task drives
// its stimulus and compares outputs against hand-computed values; outputs are
// sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int NREQ   = 2;
  localparam int WORD_W = 32;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'h1;

  logic                   CLK;
  logic                   RST;
  logic [NREQ-1:0]        req;
  logic [NREQ*OP_W-1:0]   req_aluop;
  logic [NREQ*WORD_W-1:0] req_a;
  logic [NREQ*WORD_W-1:0] req_b;
  logic [NREQ-1:0]        done;
  logic [WORD_W-1:0]      res_o;
  logic                   res_n, res_z, res_v;
  logic                   busy;
  logic [OP_W-1:0]        alu_aluop;
  logic [WORD_W-1:0]      alu_port_a, alu_port_b, alu_port_o;
  logic                   alu_n, alu_z, alu_v;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W), .OP_W(OP_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req        (req),
    .req_aluop  (req_aluop),
    .req_a      (req_a),
    .req_b      (req_b),
    .done       (done),
    .res_o      (res_o),
    .res_n      (res_n),
    .res_z      (res_z),
    .res_v      (res_v),
    .busy       (busy),
    .alu_aluop  (alu_aluop),
    .alu_port_a (alu_port_a),
    .alu_port_b (alu_port_b),
    .alu_port_o (alu_port_o),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_v      (alu_v)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stand-in for the shared combinational ALU
  always_comb begin
    case (alu_aluop)
      ALU_SUB: begin
        alu_port_o = alu_port_a - alu_port_b;
        alu_v = (alu_port_a[31] != alu_port_b[31]) && (alu_port_o[31] != alu_port_a[31]);
      end
      default: begin
        alu_port_o = alu_port_a + alu_port_b;
        alu_v = (alu_port_a[31] == alu_port_b[31]) && (alu_port_o[31] != alu_port_a[31]);
      end
    endcase
    alu_n = alu_port_o[31];
    alu_z = (alu_port_o == '0);
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [OP_W-1:0] op,
                         input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
    req_aluop[i*OP_W +: OP_W]     = op;
    req_a[i*WORD_W +: WORD_W]     = a;
    req_b[i*WORD_W +: WORD_W]     = b;
  endtask

  // Advance until done is seen (bounded); cycles counts edges taken.
  task automatic wait_for_done(output logic [NREQ-1:0] seen, output int cycles);
    seen   = '0;
    cycles = 0;
    while (seen == '0 && cycles < 8) begin
      cyc();
      cycles++;
      if (done != '0) seen = done;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; req = '0; req_aluop = '0; req_a = '0; req_b = '0;
    cyc(); cyc();
    RST = 1'b0;
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({res_o, res_n, res_z, res_v} !== 35'd0) begin errors++;
      $display("FAIL reset_res: got %h %b%b%b want 0", res_o, res_n, res_z, res_v); end
    checks++; if ({alu_aluop, alu_port_a, alu_port_b} !== 68'd0) begin errors++;
      $display("FAIL reset_alu: got %h %h %h want 0", alu_aluop, alu_port_a, alu_port_b); end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] seen;
    set_req(0, ALU_ADD, 32'h5, 32'h3);
    req = 2'b01;
    cyc();
    checks++; if (busy !== 1'b1 || done !== 2'b00) begin errors++;
      $display("FAIL single_issue: got busy=%b done=%b want busy=1 done=00", busy, done); end
    checks++; if (alu_port_a !== 32'h5 || alu_port_b !== 32'h3) begin errors++;
      $display("FAIL single_alu_in: got %h %h want 00000005 00000003", alu_port_a, alu_port_b); end
    cyc();
    seen = done;
    checks++; if (seen !== 2'b01) begin errors++; $display("FAIL single_done: got %b want 01", seen); end
    checks++; if (res_o !== 32'h8 || {res_n, res_z, res_v} !== 3'b000) begin errors++;
      $display("FAIL single_res: got %h nzv=%b%b%b want 00000008 nzv=000", res_o, res_n, res_z, res_v); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_resp: got %b want 1", busy); end
    req = 2'b00;
    cyc();
    checks++; if (done !== 2'b00 || busy !== 1'b0) begin errors++;
      $display("FAIL single_after: got done=%b busy=%b want 00 0", done, busy); end
    checks++; if (res_o !== 32'h8) begin errors++; $display("FAIL single_hold: got %h want 00000008", res_o); end
  endtask

  task automatic test_flags();
    logic [NREQ-1:0] seen;
    int cycles;
    set_req(1, ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    req = 2'b10;
    wait_for_done(seen, cycles);
    checks++; if (seen !== 2'b10 || cycles != 2) begin errors++;
      $display("FAIL ovf_done: got %b after %0d want 10 after 2", seen, cycles); end
    checks++; if (res_o !== 32'h8000_0000 || {res_n, res_z, res_v} !== 3'b101) begin errors++;
      $display("FAIL ovf_res: got %h nzv=%b%b%b want 80000000 nzv=101", res_o, res_n, res_z, res_v); end
    req = 2'b00;
    cyc();
    set_req(1, ALU_SUB, 32'h1234_5678, 32'h1234_5678);
    req = 2'b10;
    wait_for_done(seen, cycles);
    checks++; if (seen !== 2'b10 || res_o !== 32'h0 || {res_n, res_z, res_v} !== 3'b010) begin errors++;
      $display("FAIL zero_res: got %b %h nzv=%b%b%b want 10 00000000 nzv=010",
               seen, res_o, res_n, res_z, res_v); end
    req = 2'b00;
    cyc();
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] seen;
    int cycles;
    logic [NREQ-1:0]   exp_done [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [WORD_W-1:0] exp_res  [4] = '{32'd3, 32'd6, 32'd3, 32'd6};
    int                exp_cyc  [4] = '{2, 3, 3, 3};
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    set_req(1, ALU_SUB, 32'd10, 32'd4);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_for_done(seen, cycles);
      checks++; if (seen !== exp_done[i] || cycles != exp_cyc[i] || res_o !== exp_res[i]) begin errors++;
        $display("FAIL contend_%0d: got done=%b cyc=%0d res=%h want done=%b cyc=%0d res=%h",
                 i, seen, cycles, res_o, exp_done[i], exp_cyc[i], exp_res[i]); end
    end
    req = 2'b00;
    cyc();
  endtask

  task automatic test_operand_change();
    logic [NREQ-1:0] seen;
    int cycles;
    set_req(0, ALU_ADD, 32'h10, 32'h1);
    req = 2'b01;
    cyc();
    set_req(0, ALU_SUB, 32'hFF, 32'h1);
    wait_for_done(seen, cycles);
    checks++; if (seen !== 2'b01 || cycles != 1 || res_o !== 32'h11) begin errors++;
      $display("FAIL opchange: got done=%b cyc=%0d res=%h want 01 1 00000011", seen, cycles, res_o); end
    checks++; if (alu_port_a !== 32'h10 || alu_aluop !== ALU_ADD) begin errors++;
      $display("FAIL opchange_alu: got %h op=%h want 00000010 op=0", alu_port_a, alu_aluop); end
    req = 2'b00;
    cyc();
  endtask

  task automatic test_req_drop();
    logic [NREQ-1:0] seen;
    int cycles;
    set_req(1, ALU_ADD, 32'd100, 32'd23);
    req = 2'b10;
    cyc();
    req = 2'b00;
    wait_for_done(seen, cycles);
    checks++; if (seen !== 2'b10 || cycles != 1 || res_o !== 32'd123) begin errors++;
      $display("FAIL drop: got done=%b cyc=%0d res=%h want 10 1 0000007b", seen, cycles, res_o); end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] seen;
    int cycles;
    // complete an op on requester 0 so last_grant points at 0
    set_req(0, ALU_ADD, 32'd2, 32'd2);
    req = 2'b01;
    wait_for_done(seen, cycles);
    checks++; if (seen !== 2'b01 || res_o !== 32'd4) begin errors++;
      $display("FAIL rmid_pre: got %b %h want 01 00000004", seen, res_o); end
    req = 2'b00;
    cyc();
    set_req(1, ALU_ADD, 32'd1, 32'd1);
    req = 2'b10;
    cyc();
    RST = 1'b1;
    req = 2'b00;
    cyc();
    RST = 1'b0;
    checks++; if (done !== 2'b00 || busy !== 1'b0 || res_o !== 32'h0 || alu_port_a !== 32'h0) begin errors++;
      $display("FAIL rmid_out: got done=%b busy=%b res=%h a=%h want 00 0 0 0", done, busy, res_o, alu_port_a); end
    cyc();
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL rmid_nodone: got %b want 00", done); end
    set_req(0, ALU_ADD, 32'd7, 32'd1);
    set_req(1, ALU_ADD, 32'd9, 32'd9);
    req = 2'b11;
    wait_for_done(seen, cycles);
    checks++; if (seen !== 2'b01 || cycles != 2 || res_o !== 32'd8) begin errors++;
      $display("FAIL rmid_first: got done=%b cyc=%0d res=%h want 01 2 00000008", seen, cycles, res_o); end
    req = 2'b00;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_contention();
    test_operand_change();
    test_req_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
